// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
//
// Purpose: generates VGA raster timing from a single pixel clock.
// - A horizontal pixel counter and a vertical line counter run continuously.
// - A line is ordered visible, front porch, sync, back porch. A frame uses the same order.
// - The current visible pixel address is presented to a combinational drawing stage.
// - The returned colour, together with hsync and vsync, is registered, so all three
//   reach the connector on the same clock.
//
// Optional feature: when the macro VGA_TEST_PATTERN_EN is defined, pos_data is ignored.
// In its place the block emits eight vertical colour bars, each H_VISIBLE/8 columns wide,
// in this order: white, yellow, cyan, green, magenta, red, blue, black. Timing is unchanged.
// When the macro is undefined, which is the default build, no pattern logic exists.
//
// Ports:
//   vga_clk     in   1   pixel clock; every register is clocked by it
//   rst         in   1   synchronous, active-high reset
//   pos_data    in   24  RGB888 pixel for the current pos_x/pos_y (same-cycle)
//   pos_x       out  10  visible column, 0 outside the visible area
//   pos_y       out  10  visible row, 0 outside the visible area
//   data_req    out  1   pos_x/pos_y address a visible pixel
//   hsync       out  1   horizontal sync, active-low, registered
//   vsync       out  1   vertical sync, active-low, registered
//   rgb         out  24  registered pixel {R,G,B}, black during blanking
//   frame_start out  1   one-clock pulse aligned with the first visible pixel on rgb

module vga_timing_ctrl #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic [23:0] pos_data,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        data_req,
  output logic        hsync,
  output logic        vsync,
  output logic [23:0] rgb,
  output logic        frame_start
);

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Counter compare points. All of them fit in the 10-bit position width.
  localparam logic [9:0] HMax       = 10'(HTotal - 1);
  localparam logic [9:0] VMax       = 10'(VTotal - 1);
  localparam logic [9:0] HVis       = 10'(H_VISIBLE);
  localparam logic [9:0] VVis       = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;

  logic        visible;
  logic [23:0] pixel;

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HMax) begin
      h_cnt_d = '0;
      if (v_cnt_q == VMax) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drawing-stage address. This path is purely combinational, so the drawing
  // stage answers within the same clock.
  // ---------------------------------------------------------------------------
  assign visible  = (h_cnt_q < HVis) && (v_cnt_q < VVis);
  assign data_req = visible;
  assign pos_x    = visible ? h_cnt_q : 10'd0;
  assign pos_y    = visible ? v_cnt_q : 10'd0;

  // ---------------------------------------------------------------------------
  // Pixel source
  // ---------------------------------------------------------------------------
`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BarW = H_VISIBLE / 8;

  logic [2:0] bar_idx;
  logic       unused_pos_data;

  // In pattern mode the drawing stage is deliberately ignored.
  assign unused_pos_data = ^pos_data;

  // Compare against the bar edges rather than divide the column.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt_q >= 10'(k * BarW)) begin
        bar_idx = 3'(k);
      end
    end
  end

  always_comb begin
    pixel = 24'h000000;
    unique case (bar_idx)
      3'd0:    pixel = 24'hFFFFFF;
      3'd1:    pixel = 24'hFFFF00;
      3'd2:    pixel = 24'h00FFFF;
      3'd3:    pixel = 24'h00FF00;
      3'd4:    pixel = 24'hFF00FF;
      3'd5:    pixel = 24'hFF0000;
      3'd6:    pixel = 24'h0000FF;
      3'd7:    pixel = 24'h000000;
      default: pixel = 24'h000000;
    endcase
  end
`else
  assign pixel = pos_data;
`endif

  // ---------------------------------------------------------------------------
  // Registered outputs. Every value is derived from the current counters, so
  // rgb, hsync, vsync and frame_start share the same one-clock lag.
  // ---------------------------------------------------------------------------
  always_comb begin
    rgb_d         = visible ? pixel : 24'h000000;
    hsync_d       = !((h_cnt_q >= HSyncStart) && (h_cnt_q < HSyncEnd));
    vsync_d       = !((v_cnt_q >= VSyncStart) && (v_cnt_q < VSyncEnd));
    frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      rgb_q         <= 24'h000000;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL provide parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL provide parameter H_FRONT, default 16, horizontal front porch in clocks.
REQ-003 SHALL provide parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 SHALL provide parameter H_BACK, default 48, horizontal back porch in clocks.
REQ-005 SHALL provide parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 SHALL provide parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL provide parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL provide parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 SHALL have port vga_clk  input  1  pixel clock (25 MHz nominal); the block uses one clock only.
REQ-010 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-011 SHALL have port pos_data  input  24  RGB888 pixel from the drawing stage for the current pos_x/pos_y.
REQ-012 SHALL have port pos_x  output  10  visible column 0..H_VISIBLE-1, 0 outside the visible area.
REQ-013 SHALL have port pos_y  output  10  visible row 0..V_VISIBLE-1, 0 outside the visible area.
REQ-014 SHALL have port data_req  output  1  high when pos_x/pos_y address a visible pixel.
REQ-015 SHALL have port hsync  output  1  horizontal sync, active-low.
REQ-016 SHALL have port vsync  output  1  vertical sync, active-low.
REQ-017 SHALL have port rgb  output  24  pixel to the DAC/connector, {R,G,B}.
REQ-018 SHALL have port frame_start  output  1  one-clock pulse at the first visible pixel of each frame.

Function
REQ-019 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H_* params) each clock, wrapping to 0.
REQ-020 v_cnt SHALL increment when h_cnt wraps, counting 0..V_TOTAL-1 and wrapping to 0 when both counters are at their maximum.
REQ-021 Line order SHALL be visible, front porch, sync, back porch; same for frame.
REQ-022 data_req SHALL be high iff h_cnt < H_VISIBLE and v_cnt < V_VISIBLE, combinationally from the counters.
REQ-023 pos_x/pos_y SHALL equal h_cnt/v_cnt when data_req is high, else 0.
REQ-024 pos_data SHALL be sampled in the same clock that pos_x/pos_y are presented (the drawing stage is combinational).
REQ-025 rgb SHALL be registered: rgb <= data_req ? pos_data : 24'h000000; latency one clock from pos_x/pos_y.
REQ-026 hsync SHALL be registered low iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC, so it stays aligned with rgb.
REQ-027 vsync SHALL be registered low iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC, for whole lines.
REQ-028 frame_start SHALL be registered high for exactly one clock, the clock after h_cnt=0 and v_cnt=0.
REQ-029 Blanking output SHALL be exactly 24'h000000 regardless of pos_data.

Reset
REQ-030 While rst is high at a vga_clk edge, h_cnt and v_cnt SHALL load 0, rgb 0, hsync 1, vsync 1, frame_start 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame; the first clock after release SHALL present pos_x=0, pos_y=0, data_req=1.
REQ-032 No output SHALL change asynchronously to vga_clk.

Configuration
REQ-033 Macro VGA_TEST_PATTERN_EN, when defined, SHALL replace pos_data with eight vertical colour bars of H_VISIBLE/8 columns each (white, yellow, cyan, green, magenta, red, blue, black), timing unchanged.
REQ-034 Without VGA_TEST_PATTERN_EN, rgb SHALL follow pos_data per REQ-025 and no pattern logic SHALL be present.

Verification
REQ-035 Release rst, run one line -> hsync low for clocks 656..751 of the line (96 clocks), line period 800 clocks.
REQ-036 Run one full frame -> vsync low for lines 490..491 (1600 clocks), frame period 420000 clocks, frame_start exactly once.
REQ-037 Drive pos_data=24'h00FF00 constant -> rgb=24'h00FF00 for 640 clocks per visible line, 24'h000000 for the other 160, one-clock lag after data_req.
REQ-038 At h_cnt=639, v_cnt=479 -> pos_x=639, pos_y=479, data_req=1; next clock pos_x=0, pos_y=0, data_req=0.
REQ-039 Assert rst for 3 clocks at line 200 pixel 300 -> outputs at reset values; after release frame restarts at pos (0,0) with frame_start one clock later.
REQ-040 With VGA_TEST_PATTERN_EN defined, pos_data=24'h123456 -> rgb=24'hFFFFFF for columns 0..79, 24'h000000 for 560..639.
